player_move_ctrl: RTL and testbench

- Downstream consumer of the map tile table.
- Converts one-cycle direction pulses into player grid moves by issuing a tile lookup on one map read port (x/y out, 3-bit tile in), then committing or rejecting the move.
- Tracks player position, step count and stairs arrival.
- Resets the player to the start cell whenever the map selection changes.

---
 rtl/player_move_ctrl_pkg.sv | 27 ++
 rtl/player_move_ctrl_if.sv | 30 +++
 rtl/move_target_calc.sv | 31 +++
 rtl/player_move_ctrl.sv | 121 ++++++++++++
 tb/tb_player_move_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/player_move_ctrl_pkg.sv
// player_move_ctrl_pkg: tile codes, move directions and move FSM states shared by the map table and the player controller
package player_move_ctrl_pkg;

    localparam logic [2:0] MAP_ROAD0  = 3'b000;
    localparam logic [2:0] MAP_ROAD1  = 3'b001;
    localparam logic [2:0] MAP_WALL   = 3'b010;
    localparam logic [2:0] MAP_STAIRS = 3'b011;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_QUERY = 1'b1
    } move_state_t;

    // Reserved codes 1xx are treated as wall.
    function automatic logic walkable(input logic [2:0] tile);
        return !tile[2] && tile != MAP_WALL;
    endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// player_move_ctrl_if: buttons, map read port and player status bundle
interface player_move_ctrl_if #(
    parameter int STEP_W = 10
);
    logic              btn_up;
    logic              btn_down;
    logic              btn_left;
    logic              btn_right;
    logic              sw_map;
    logic [5:0]        map_x;
    logic [5:0]        map_y;
    logic [2:0]        map_tile;
    logic [5:0]        pos_x;
    logic [5:0]        pos_y;
    logic [STEP_W-1:0] step_count;
    logic              on_stairs;
    logic              stairs_hit;
    logic              bump;
    logic              busy;

    modport master (
        input  btn_up, btn_down, btn_left, btn_right, sw_map, map_tile,
        output map_x, map_y, pos_x, pos_y, step_count, on_stairs, stairs_hit, bump, busy
    );

    modport slave (
        output btn_up, btn_down, btn_left, btn_right, sw_map, map_tile,
        input  map_x, map_y, pos_x, pos_y, step_count, on_stairs, stairs_hit, bump, busy
    );
endinterface

// File: rtl/move_target_calc.sv
// move_target_calc: neighbour cell for a direction, bounds checked before any arithmetic
module move_target_calc
    import player_move_ctrl_pkg::*;
#(
    parameter int MAP_W = 20,
    parameter int MAP_H = 10
) (
    input  logic [5:0] pos_x,
    input  logic [5:0] pos_y,
    input  dir_t       dir,
    output logic [5:0] tgt_x,
    output logic [5:0] tgt_y,
    output logic       oob
);
    localparam logic [5:0] X_MAX = 6'(MAP_W - 1);
    localparam logic [5:0] Y_MAX = 6'(MAP_H - 1);

    // An out-of-range move leaves the target on the current cell.
    always_comb begin
        tgt_x = pos_x;
        tgt_y = pos_y;
        oob   = 1'b0;
        case (dir)
            DIR_UP:    if (pos_y == 6'd0)  oob = 1'b1; else tgt_y = pos_y - 6'd1;
            DIR_DOWN:  if (pos_y == Y_MAX) oob = 1'b1; else tgt_y = pos_y + 6'd1;
            DIR_LEFT:  if (pos_x == 6'd0)  oob = 1'b1; else tgt_x = pos_x - 6'd1;
            DIR_RIGHT: if (pos_x == X_MAX) oob = 1'b1; else tgt_x = pos_x + 6'd1;
            default:   oob = 1'b0;
        endcase
    end
endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: turns direction pulses into map-checked grid moves
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int MAP_W   = 20,
    parameter int MAP_H   = 10,
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int STEP_W  = 10
) (
    input logic                clk,
    input logic                rst,
    player_move_ctrl_if.master bus
);
    localparam logic [5:0] SX = 6'(START_X);
    localparam logic [5:0] SY = 6'(START_Y);

    move_state_t       state;
    move_state_t       state_next;
    dir_t              dir;
    logic [5:0]        tgt_x;
    logic [5:0]        tgt_y;
    logic              oob;
    logic              tgt_oob;
    logic              sw_map_q;
    logic              map_change;
    logic [5:0]        map_x;
    logic [5:0]        map_y;
    logic [5:0]        pos_x;
    logic [5:0]        pos_y;
    logic [STEP_W-1:0] step_count;
    logic              on_stairs;
    logic              stairs_hit;
    logic              bump;

    assign map_change = bus.sw_map != sw_map_q;

    // Fixed priority up > down > left > right; lower simultaneous pulses are dropped.
    always_comb begin
        dir = bus.btn_up    ? DIR_UP    :
              bus.btn_down  ? DIR_DOWN  :
              bus.btn_left  ? DIR_LEFT  :
              bus.btn_right ? DIR_RIGHT : DIR_NONE;
    end

    move_target_calc #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_target (
        .pos_x (pos_x),
        .pos_y (pos_y),
        .dir   (dir),
        .tgt_x (tgt_x),
        .tgt_y (tgt_y),
        .oob   (oob)
    );

    // Move FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // A map change abandons any query; every query lasts exactly one cycle.
    always_comb begin
        state_next = S_IDLE;
        if (!map_change && state == S_IDLE && dir != DIR_NONE) state_next = S_QUERY;
    end

    // Lookup address, committed position, step count and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_map_q   <= bus.sw_map;
            tgt_oob    <= 1'b0;
            map_x      <= SX;
            map_y      <= SY;
            pos_x      <= SX;
            pos_y      <= SY;
            step_count <= '0;
            on_stairs  <= 1'b0;
            stairs_hit <= 1'b0;
            bump       <= 1'b0;
        end else begin
            sw_map_q   <= bus.sw_map;
            stairs_hit <= 1'b0;
            bump       <= 1'b0;
            if (map_change) begin
                map_x      <= SX;
                map_y      <= SY;
                pos_x      <= SX;
                pos_y      <= SY;
                step_count <= '0;
                on_stairs  <= 1'b0;
            end else if (state == S_IDLE) begin
                map_x   <= tgt_x;
                map_y   <= tgt_y;
                tgt_oob <= oob;
            end else if (!tgt_oob && walkable(bus.map_tile)) begin
                pos_x      <= map_x;
                pos_y      <= map_y;
                step_count <= step_count + STEP_W'(~&step_count);
                on_stairs  <= bus.map_tile == MAP_STAIRS;
                stairs_hit <= bus.map_tile == MAP_STAIRS;
            end else begin
                map_x <= pos_x;
                map_y <= pos_y;
                bump  <= 1'b1;
            end
        end
    end

    assign bus.map_x      = map_x;
    assign bus.map_y      = map_y;
    assign bus.pos_x      = pos_x;
    assign bus.pos_y      = pos_y;
    assign bus.step_count = step_count;
    assign bus.on_stairs  = on_stairs;
    assign bus.stairs_hit = stairs_hit;
    assign bus.bump       = bump;
    assign bus.busy       = state == S_QUERY;
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed checks of player_move_ctrl against a two-map tile table
module tb_player_move_ctrl;
    import player_move_ctrl_pkg::*;

    localparam logic [3:0] U = 4'b1000;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] L = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    player_move_ctrl_if #(.STEP_W(10)) bus ();
    player_move_ctrl_if #(.STEP_W(10)) bus0 ();
    player_move_ctrl_if #(.STEP_W(2))  bus2 ();

    player_move_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    player_move_ctrl #(.START_X(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    player_move_ctrl #(.STEP_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Map 1 (m=0): walled border, stairs at (14,2), reserved code at (2,2), roads elsewhere.
    // Map 2 (m=1): walled border, wall at (4,1), roads elsewhere.
    function automatic logic [2:0] tile(input logic m, input logic [5:0] x, input logic [5:0] y);
        if (x == 6'd0 || y == 6'd0 || x >= 6'd19 || y >= 6'd9) return MAP_WALL;
        if (!m) begin
            if (x == 6'd14 && y == 6'd2) return MAP_STAIRS;
            if (x == 6'd2 && y == 6'd2) return 3'b100;
            return x[0] ? MAP_ROAD1 : MAP_ROAD0;
        end
        if (x == 6'd4 && y == 6'd1) return MAP_WALL;
        return MAP_ROAD0;
    endfunction

    assign bus.map_tile  = tile(bus.sw_map, bus.map_x, bus.map_y);
    assign bus0.map_tile = tile(bus0.sw_map, bus0.map_x, bus0.map_y);
    assign bus2.map_tile = tile(bus2.sw_map, bus2.map_x, bus2.map_y);

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
        tick();
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0;
    endtask

    task automatic move(input logic [3:0] b);
        press(b);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.sw_map} = 5'b0;
        {bus0.btn_up, bus0.btn_down, bus0.btn_left, bus0.btn_right, bus0.sw_map} = 5'b0;
        {bus2.btn_up, bus2.btn_down, bus2.btn_left, bus2.btn_right, bus2.sw_map} = 5'b0;
        #1;
        do_reset();

        check("rst_pos_x", bus.pos_x, 1);
        check("rst_pos_y", bus.pos_y, 1);
        check("rst_map_x", bus.map_x, 1);
        check("rst_step", bus.step_count, 0);
        check("rst_pulses", {bus.bump, bus.stairs_hit, bus.on_stairs, bus.busy}, 0);

        press(R);
        check("right_busy", bus.busy, 1);
        check("right_map_x", bus.map_x, 2);
        tick();
        check("right_pos_x", bus.pos_x, 2);
        check("right_step", bus.step_count, 1);
        check("right_bump", bus.bump, 0);
        check("right_busy_done", bus.busy, 0);
        move(L);
        check("left_pos_x", bus.pos_x, 1);
        check("left_step", bus.step_count, 2);

        press(U);
        check("up_map_y", bus.map_y, 0);
        tick();
        check("up_bump", bus.bump, 1);
        check("up_pos_y", bus.pos_y, 1);
        check("up_step", bus.step_count, 2);
        check("up_map_y_back", bus.map_y, 1);
        tick();
        check("up_bump_once", bus.bump, 0);
        move(U | R);
        check("prio_bump", bus.bump, 1);
        check("prio_pos_x", bus.pos_x, 1);

        move(R);
        move(D);
        check("reserved_bump", bus.bump, 1);
        check("reserved_pos_y", bus.pos_y, 1);
        for (int i = 0; i < 12; i++) move(R);
        check("walk_pos_x", bus.pos_x, 14);
        check("walk_step", bus.step_count, 15);
        move(D);
        check("stairs_hit", bus.stairs_hit, 1);
        check("stairs_on", bus.on_stairs, 1);
        check("stairs_pos_y", bus.pos_y, 2);
        tick();
        check("stairs_hit_once", bus.stairs_hit, 0);
        check("stairs_on_hold", bus.on_stairs, 1);
        move(U);
        check("leave_on", bus.on_stairs, 0);
        move(L);
        check("leave_pos_x", bus.pos_x, 13);
        check("leave_step", bus.step_count, 18);

        do_reset();
        check("rst2_pos_x", bus.pos_x, 1);
        check("rst2_step", bus.step_count, 0);
        press(R);
        press(D);
        tick();
        check("busy_drop_pos_x", bus.pos_x, 2);
        check("busy_drop_pos_y", bus.pos_y, 1);
        check("busy_drop_step", bus.step_count, 1);
        check("busy_drop_idle", bus.busy, 0);

        move(R);
        check("pre_change_pos_x", bus.pos_x, 3);
        press(R);
        bus.sw_map = 1'b1;
        tick();
        check("change_pos_x", bus.pos_x, 1);
        check("change_pos_y", bus.pos_y, 1);
        check("change_map_x", bus.map_x, 1);
        check("change_step", bus.step_count, 0);
        check("change_pulses", {bus.bump, bus.stairs_hit, bus.busy}, 0);
        move(R);
        move(R);
        check("map2_pos_x", bus.pos_x, 3);
        move(R);
        check("map2_bump", bus.bump, 1);
        check("map2_pos_stay", bus.pos_x, 3);
        check("map2_step", bus.step_count, 2);
        bus.sw_map = 1'b0;
        press(R);
        check("change_drop_busy", bus.busy, 0);
        tick();
        check("change_drop_pos_x", bus.pos_x, 1);
        check("change_drop_step", bus.step_count, 0);

        check("oob_start_x", bus0.pos_x, 0);
        bus0.btn_left = 1'b1;
        tick();
        bus0.btn_left = 1'b0;
        check("oob_busy", bus0.busy, 1);
        check("oob_map_x", bus0.map_x, 0);
        tick();
        check("oob_bump", bus0.bump, 1);
        check("oob_pos_x", bus0.pos_x, 0);
        check("oob_step", bus0.step_count, 0);

        for (int i = 0; i < 5; i++) begin
            bus2.btn_right = 1'b1;
            tick();
            bus2.btn_right = 1'b0;
            tick();
        end
        check("sat_pos_x", bus2.pos_x, 6);
        check("sat_step", bus2.step_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
